// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
//
// Shared definitions for the iterative multiply/divide unit. The decoder
// imports the same op constants so the encoding lives in exactly one place.
//
// Contents:
//   MULDIV_WIDTH  default operand/result width (also the iteration count)
//   op_t          2-bit op code type
//   OP_MUL        low half of the unsigned product
//   OP_MULHU      high half of the unsigned product
//   OP_DIVU       unsigned quotient
//   OP_REMU       unsigned remainder
//   state_t       control FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef logic [1:0] op_t;

    // Bit 1 selects divide, bit 0 selects the upper half of the accumulator
    // (high product or remainder) when the result is taken.
    localparam op_t OP_MUL   = 2'b00;
    localparam op_t OP_MULHU = 2'b01;
    localparam op_t OP_DIVU  = 2'b10;
    localparam op_t OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : muldiv_seq_pkg

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU). One
// iteration per clock for WIDTH clocks, then a single-cycle registered done
// pulse with the result. The core stalls on busy.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, only sampled in IDLE
//   op      in   2-bit op code (see muldiv_seq_pkg)
//   a       in   multiplicand / dividend, captured on accepted start
//   b       in   multiplier / divisor, captured on accepted start
//   busy    out  high while iterating (state RUN)
//   done    out  one-cycle pulse, result valid in that cycle
//   result  out  final value, held until the next accepted start
//
// Handshake: start is a level request observed only while IDLE; there is no
// ready signal, a request raised in RUN or DONE is dropped, not queued. busy
// and done are mutually exclusive and both come straight from flops.
//
// Timing, with start sampled at edge E0: busy is high from E0 to E32, done is
// high from E32 to E33, and the FSM is back in IDLE after E33.
//
// WIDTH is expected to be a power of two (the bit index arithmetic relies on
// WIDTH-1-i == ~i for an index of $clog2(WIDTH) bits).
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int ACC_W = 2 * WIDTH;
    // One extra bit for the multiply carry / shifted-out remainder bit, and
    // one more so the divide borrow appears as the sign of the sum.
    localparam int ALU_W = WIDTH + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    op_t                op_q,     op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q,   done_d;

    // ------------------------------------------------------------------
    // Shared iteration datapath
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   bit_idx;
    logic               is_div;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               mul_bit;
    logic               div_bit;
    logic [WIDTH-1:0]   mul_addend;
    logic [ALU_W-1:0]   alu_x;
    logic [ALU_W-1:0]   alu_y;
    logic [ALU_W-1:0]   alu_cin;
    logic [ALU_W-1:0]   alu_sum;
    logic               borrow;
    logic [ACC_W-1:0]   acc_step;
    logic               last_iter;

    always_comb begin
        bit_idx    = cnt_q[IDX_W-1:0];
        is_div     = op_q[1];
        acc_hi     = acc_q[ACC_W-1:WIDTH];
        acc_lo     = acc_q[WIDTH-1:0];

        // Multiply walks the multiplier LSB first.
        mul_bit    = b_q[bit_idx];
        mul_addend = mul_bit ? a_q : {WIDTH{1'b0}};

        // The accumulator is cleared at start, so instead of preloading the
        // dividend into the quotient half it is fed in MSB first from a_q;
        // the shift of {rem, quo} then only has to bring in this bit.
        div_bit    = a_q[~bit_idx];

        // One adder serves both paths: add for multiply, x + ~y + 1 for
        // the restoring subtract.
        if (is_div) begin
            alu_x   = {1'b0, acc_hi, div_bit};
            alu_y   = ~{2'b00, b_q};
            alu_cin = ALU_W'(1);
        end else begin
            alu_x   = {2'b00, acc_hi};
            alu_y   = {2'b00, mul_addend};
            alu_cin = ALU_W'(0);
        end
        alu_sum = alu_x + alu_y + alu_cin;

        // Operands are below 2^(WIDTH+1), so a negative difference shows up
        // as the top bit of the sum.
        borrow  = alu_sum[ALU_W-1];

        if (is_div) begin
            // When there is a borrow the shifted remainder is below b and so
            // still fits in WIDTH bits: keep it unchanged (restore).
            if (borrow) begin
                acc_step = {alu_x[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {alu_sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Carry-in of the upper half lands in the accumulator MSB.
            acc_step = {alu_sum[WIDTH:0], acc_lo[WIDTH-1:1]};
        end

        last_iter = (cnt_q == CNT_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end

            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_ONE;
                if (last_iter) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    // Result is taken from the final iteration directly so it
                    // is registered on the same edge that raises done.
                    unique case (op_q)
                        OP_MUL:   result_d = acc_step[WIDTH-1:0];
                        OP_MULHU: result_d = acc_step[ACC_W-1:WIDTH];
                        OP_DIVU:  result_d = acc_step[WIDTH-1:0];
                        OP_REMU:  result_d = acc_step[ACC_W-1:WIDTH];
                        default:  result_d = acc_step[WIDTH-1:0];
                    endcase
                end
            end

            DONE: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule : muldiv_seq

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//
// Directed plus a few random operations against muldiv_seq. Expected results
// are pushed to exp_q when an operation is driven and popped by the monitor
// when done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int n_pushed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model built from native arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per done pulse, and watches busy/done overlap
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy === 1'b1 || done === 1'b1)
        check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_done observed=done expected=no_done result=0x%0h", result);
        end
        if (exp_q.size() != 0) check("result", {32'd0, result}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Issues one operation, scrambles the inputs after acceptance, and checks
  // busy length, done latency and that done is a one-cycle pulse with a held
  // result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] expv, input string tag);
    int busy_n;
    int lat;
    bit seen;
    exp_q.push_back(expv);
    n_pushed++;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    busy_n = 0; lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      lat++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_result_held"}, {32'd0, result}, {32'd0, expv});
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int busy_seen;
    int dones_before;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   o;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Directed arithmetic cases
    run_op(2'b00, 32'd7,          32'd6,          32'd42,         "mul_7x6");
    run_op(2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  "mul_max");
    run_op(2'b10, 32'd100,        32'd7,          32'd14,         "divu_100_7");
    run_op(2'b11, 32'd100,        32'd7,          32'd2,          "remu_100_7");
    run_op(2'b10, 32'h8000_0000,  32'd1,          32'h8000_0000,  "divu_by_one");
    run_op(2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_by_zero");
    run_op(2'b11, 32'd5,          32'd0,          32'd5,          "remu_by_zero");
    run_op(2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "remu_big_rem");
    run_op(2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          "divu_max");
    run_op(2'b01, 32'h8000_0000,  32'd2,          32'd1,          "mulhu_carry");

    // start while RUN (at E5) and while DONE is ignored
    exp_q.push_back(32'h0001_2340);
    n_pushed++;
    dones_before = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    busy_seen = 0;
    while (done !== 1'b1 && busy_seen < 100) begin
      busy_seen++;
      @(negedge clk);
    end
    check("ign_done_seen", {63'd0, done}, 64'd1);
    start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_pulse", {63'd0, done}, 64'd0);
    busy_seen = 0;
    repeat (40) begin
      if (busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    check("ign_no_restart", 64'(busy_seen), 64'd0);
    check("ign_one_done", 64'(done_cnt - dones_before), 64'd1);
    check("ign_result_held", {32'd0, result}, 64'h0001_2340);

    // Reset at E10 of a DIVU aborts it
    dones_before = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dones_before), 64'd0);
    check("abort_result_after", {32'd0, result}, 64'd0);
    run_op(2'b00, 32'd3, 32'd3, 32'd9, "mul_after_reset");

    // Random operations
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op(o, x, y, model(o, x, y), "rand");
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("total_dones", 64'(done_cnt), 64'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muldiv_seq
